// File: rtl/exc_pkg.sv
// Shared constants for the MEM-stage exception controller: CP0 exception codes,
// Status/Cause bit positions, the FSM state type and the interrupt-pending helper.
package exc_pkg;

  localparam logic [4:0] EC_INT  = 5'h00;
  localparam logic [4:0] EC_ADEL = 5'h04;
  localparam logic [4:0] EC_ADES = 5'h05;
  localparam logic [4:0] EC_SYS  = 5'h08;
  localparam logic [4:0] EC_BP   = 5'h09;
  localparam logic [4:0] EC_RI   = 5'h0a;
  localparam logic [4:0] EC_OV   = 5'h0c;
  localparam logic [4:0] EC_NONE = 5'h10;
  localparam logic [4:0] EC_ERET = 5'h11;

  localparam int SR_IE    = 0;
  localparam int SR_EXL   = 1;
  localparam int SR_IM_LO = 8;
  localparam int SR_IM_HI = 15;
  localparam int CR_IP_LO = 8;
  localparam int CR_IP_HI = 15;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_WAIT_JUMP = 1'b1
  } exc_state_e;

  // Timer interrupt is OR-ed onto IP7; interrupts are blocked while EXL is set.
  function automatic logic int_pending(input logic [31:0] status,
                                       input logic [31:0] cause,
                                       input logic        int_time);
    logic [7:0] ip;
    ip = {cause[CR_IP_HI] | int_time, cause[CR_IP_HI-1:CR_IP_LO]} & status[SR_IM_HI:SR_IM_LO];
    return (ip != 8'h00) && status[SR_IE] && !status[SR_EXL];
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Fixed-priority encoder from the per-instruction exception flags (plus a
// pending interrupt) to a single CP0 exception code.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic       int_pend_i,
  input  logic       if_adel_i,
  input  logic       ri_i,
  input  logic       ov_i,
  input  logic       sys_i,
  input  logic       bp_i,
  input  logic       eret_i,
  input  logic       adel_i,
  input  logic       ades_i,
  output logic [4:0] code_o
);

  // Highest-priority source wins; no source yields EC_NONE.
  always_comb begin
    code_o = EC_NONE;
    if (int_pend_i)     code_o = EC_INT;
    else if (if_adel_i) code_o = EC_ADEL;
    else if (ri_i)      code_o = EC_RI;
    else if (ov_i)      code_o = EC_OV;
    else if (sys_i)     code_o = EC_SYS;
    else if (bp_i)      code_o = EC_BP;
    else if (eret_i)    code_o = EC_ERET;
    else if (adel_i)    code_o = EC_ADEL;
    else if (ades_i)    code_o = EC_ADES;
    else                code_o = EC_NONE;
  end

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception producer feeding CP0; stalls the pipeline until CP0 redirects.
// Optional redirect timeout enabled by defining EXC_TIMEOUT_EN.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] EXC_VECTOR     = 32'hBFC00380
) (
  input  logic        cpu_clk_75M,
  input  logic        cpu_rst_n,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_is_branch_i,
  input  logic        exc_if_adel_i,
  input  logic        exc_ri_i,
  input  logic        exc_ov_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_eret_i,
  input  logic        exc_adel_i,
  input  logic        exc_ades_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] status_i,
  input  logic [31:0] cause_i,
  input  logic        int_time_i,
  input  logic        exc_jump_flag_i,
  output logic [4:0]  exc_code_o,
  output logic [31:0] exc_epc_o,
  output logic [31:0] exc_badvaddr_o,
  output logic        in_delay_o,
  output logic        stall_req_o,
  output logic        timeout_o
);

  exc_state_e state_q, state_d;
  logic       in_delay_q, in_delay_d;
  logic       int_pend_s;
  logic [4:0] enc_code_s;
  logic       active_s;
  logic       raise_s;

  assign int_pend_s = int_pending(status_i, cause_i, int_time_i);
  assign active_s   = mem_valid_i && (state_q == ST_IDLE);
  assign raise_s    = active_s && (enc_code_s != EC_NONE);

  exc_prio_enc u_prio (
    .int_pend_i (int_pend_s),
    .if_adel_i  (exc_if_adel_i),
    .ri_i       (exc_ri_i),
    .ov_i       (exc_ov_i),
    .sys_i      (exc_sys_i),
    .bp_i       (exc_bp_i),
    .eret_i     (exc_eret_i),
    .adel_i     (exc_adel_i),
    .ades_i     (exc_ades_i),
    .code_o     (enc_code_s)
  );

  // Zero-latency CP0 view; a winning code of AdEL with the fetch flag set came from fetch.
  always_comb begin
    exc_code_o     = EC_NONE;
    exc_epc_o      = 32'h0000_0000;
    exc_badvaddr_o = 32'h0000_0000;
    in_delay_o     = 1'b0;
    if (raise_s) begin
      exc_code_o = enc_code_s;
      exc_epc_o  = in_delay_q ? (mem_pc_i - 32'd4) : mem_pc_i;
      in_delay_o = in_delay_q;
      if ((enc_code_s == EC_ADEL) && exc_if_adel_i) begin
        exc_badvaddr_o = mem_pc_i;
      end else if ((enc_code_s == EC_ADEL) || (enc_code_s == EC_ADES)) begin
        exc_badvaddr_o = mem_addr_i;
      end else begin
        exc_badvaddr_o = 32'h0000_0000;
      end
    end else begin
      exc_code_o = EC_NONE;
    end
  end

  assign stall_req_o = (state_q == ST_WAIT_JUMP);

`ifdef EXC_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  logic [TW-1:0] timer_q, timer_d;
  logic          timeout_q, timeout_d;

  // Next state: acknowledge has precedence over an expiring timer.
  always_comb begin
    state_d    = state_q;
    in_delay_d = in_delay_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = {TW{1'b0}};
        if (raise_s) begin
          state_d    = ST_WAIT_JUMP;
          in_delay_d = 1'b0;
        end else if (active_s) begin
          in_delay_d = mem_is_branch_i;
        end else begin
          in_delay_d = in_delay_q;
        end
      end
      ST_WAIT_JUMP: begin
        if (exc_jump_flag_i) begin
          state_d = ST_IDLE;
          timer_d = {TW{1'b0}};
        end else if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d   = ST_IDLE;
          timer_d   = {TW{1'b0}};
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = {TW{1'b0}};
      end
    endcase
  end

  // State, delay-slot, timer and sticky timeout registers.
  always_ff @(posedge cpu_clk_75M) begin
    if (!cpu_rst_n) begin
      state_q    <= ST_IDLE;
      in_delay_q <= 1'b0;
      timer_q    <= {TW{1'b0}};
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_delay_q <= in_delay_d;
      timer_q    <= timer_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

  logic unused_s;
  assign unused_s = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0], EXC_VECTOR};
`else
  // Next state: without a timer, only the CP0 acknowledge leaves WAIT_JUMP.
  always_comb begin
    state_d    = state_q;
    in_delay_d = in_delay_q;
    case (state_q)
      ST_IDLE: begin
        if (raise_s) begin
          state_d    = ST_WAIT_JUMP;
          in_delay_d = 1'b0;
        end else if (active_s) begin
          in_delay_d = mem_is_branch_i;
        end else begin
          in_delay_d = in_delay_q;
        end
      end
      ST_WAIT_JUMP: begin
        if (exc_jump_flag_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_JUMP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and delay-slot registers.
  always_ff @(posedge cpu_clk_75M) begin
    if (!cpu_rst_n) begin
      state_q    <= ST_IDLE;
      in_delay_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_delay_q <= in_delay_d;
    end
  end

  assign timeout_o = 1'b0;

  logic unused_s;
  assign unused_s = ^{status_i[31:16], status_i[7:2], cause_i[31:16], cause_i[7:0], EXC_VECTOR,
                      (TIMEOUT_CYCLES != 0)};
`endif

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed test-plan steps followed by random
// traffic, all compared against a behavioural model of the exception rules.
module tb_exc_ctrl;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_valid, mem_is_branch;
  logic [31:0] mem_pc, mem_addr, status, cause;
  logic        f_if_adel, f_ri, f_ov, f_sys, f_bp, f_eret, f_adel, f_ades;
  logic        int_time, jump;
  logic [4:0]  exc_code;
  logic [31:0] exc_epc, exc_bad;
  logic        in_delay, stall, timeout;

  always #5 clk = ~clk;

  exc_ctrl #(.TIMEOUT_CYCLES(TO), .EXC_VECTOR(32'hBFC00380)) dut (
    .cpu_clk_75M     (clk),
    .cpu_rst_n       (rst_n),
    .mem_valid_i     (mem_valid),
    .mem_pc_i        (mem_pc),
    .mem_is_branch_i (mem_is_branch),
    .exc_if_adel_i   (f_if_adel),
    .exc_ri_i        (f_ri),
    .exc_ov_i        (f_ov),
    .exc_sys_i       (f_sys),
    .exc_bp_i        (f_bp),
    .exc_eret_i      (f_eret),
    .exc_adel_i      (f_adel),
    .exc_ades_i      (f_ades),
    .mem_addr_i      (mem_addr),
    .status_i        (status),
    .cause_i         (cause),
    .int_time_i      (int_time),
    .exc_jump_flag_i (jump),
    .exc_code_o      (exc_code),
    .exc_epc_o       (exc_epc),
    .exc_badvaddr_o  (exc_bad),
    .in_delay_o      (in_delay),
    .stall_req_o     (stall),
    .timeout_o       (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: waiting for redirect, delay-slot flag, wait length, sticky timeout.
  bit m_wait, m_delay, m_timeout;
  int m_waited;
  logic [4:0]  e_code;
  logic [31:0] e_epc, e_bad;
  logic        e_delay, e_stall, e_to;
  logic [4:0]  prio_codes [8] = '{5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09, 5'h11, 5'h04, 5'h05};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_outputs();
    bit flags [8];
    bit pend;
    int win;
    pend = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (status[8+i] && (cause[8+i] || (i == 7 && int_time))) pend = 1'b1;
    end
    pend = pend && status[0] && !status[1];
    flags = '{f_if_adel, f_ri, f_ov, f_sys, f_bp, f_eret, f_adel, f_ades};
    e_stall = m_wait;
    e_to    = m_timeout;
    e_code  = 5'h10;
    e_epc   = 32'h0;
    e_bad   = 32'h0;
    e_delay = 1'b0;
    if (mem_valid && !m_wait) begin
      win = -1;
      if (pend) e_code = 5'h00;
      else begin
        for (int i = 7; i >= 0; i--) if (flags[i]) win = i;
        if (win >= 0) e_code = prio_codes[win];
      end
      if (e_code != 5'h10) begin
        e_epc   = m_delay ? mem_pc - 32'd4 : mem_pc;
        e_delay = m_delay;
        if (win == 0) e_bad = mem_pc;
        else if (win == 6 || win == 7) e_bad = mem_addr;
      end
    end
  endtask

  task automatic check_now();
    @(negedge clk);
    model_outputs();
    chk("code", {27'd0, exc_code}, {27'd0, e_code});
    chk("epc", exc_epc, e_epc);
    chk("badvaddr", exc_bad, e_bad);
    chk("in_delay", {31'd0, in_delay}, {31'd0, e_delay});
    chk("stall", {31'd0, stall}, {31'd0, e_stall});
    chk("timeout", {31'd0, timeout}, {31'd0, e_to});
  endtask

  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      m_wait = 0; m_delay = 0; m_waited = 0; m_timeout = 0;
    end else if (m_wait) begin
      if (jump) begin
        m_wait = 0; m_waited = 0;
      end else begin
        m_waited++;
`ifdef EXC_TIMEOUT_EN
        if (m_waited == TO) begin
          m_wait = 0; m_waited = 0; m_timeout = 1;
        end
`endif
      end
    end else if (e_code != 5'h10) begin
      m_wait = 1; m_delay = 0;
    end else if (mem_valid) begin
      m_delay = mem_is_branch;
    end
    #1;
  endtask

  task automatic step();
    check_now();
    advance();
  endtask

  task automatic clr();
    mem_valid = 0; mem_is_branch = 0; mem_pc = 32'h0; mem_addr = 32'h0;
    status = 32'h0; cause = 32'h0; int_time = 0; jump = 0;
    f_if_adel = 0; f_ri = 0; f_ov = 0; f_sys = 0; f_bp = 0; f_eret = 0; f_adel = 0; f_ades = 0;
  endtask

  task automatic ack();
    clr(); jump = 1; step();
    jump = 0; step();
  endtask

  initial begin
    clr();
    rst_n = 0;
    m_wait = 0; m_delay = 0; m_waited = 0; m_timeout = 0;
    @(posedge clk); #1;
    check_now();
    chk("rst_code", {27'd0, exc_code}, 32'h10);
    chk("rst_stall", {31'd0, stall}, 32'h0);
    advance();
    rst_n = 1;

    // Overflow, not in a delay slot.
    mem_valid = 1; mem_pc = 32'h80001000; f_ov = 1;
    check_now();
    chk("ov_code", {27'd0, exc_code}, 32'h0c);
    chk("ov_epc", exc_epc, 32'h80001000);
    chk("ov_bad", exc_bad, 32'h0);
    advance();
    clr(); mem_valid = 1; f_sys = 1;
    check_now();
    chk("ov_stall", {31'd0, stall}, 32'h1);
    chk("wait_ignores_flags", {27'd0, exc_code}, 32'h10);
    advance();
    step(); step();
    clr(); jump = 1;
    check_now();
    chk("ack_cycle_stall", {31'd0, stall}, 32'h1);
    advance();
    jump = 0;
    check_now();
    chk("post_ack_stall", {31'd0, stall}, 32'h0);
    advance();

    // Syscall in a branch delay slot.
    mem_valid = 1; mem_pc = 32'h80002000; mem_is_branch = 1;
    step();
    mem_is_branch = 0; mem_pc = 32'h80002004; f_sys = 1;
    check_now();
    chk("ds_code", {27'd0, exc_code}, 32'h08);
    chk("ds_epc", exc_epc, 32'h80002000);
    chk("ds_delay", {31'd0, in_delay}, 32'h1);
    advance();
    ack();

    // Interrupt beats syscall; EXL masks it.
    mem_valid = 1; mem_pc = 32'h80003000; f_sys = 1; status = 32'h00008001; int_time = 1;
    check_now();
    chk("int_code", {27'd0, exc_code}, 32'h00);
    chk("int_epc", exc_epc, 32'h80003000);
    advance();
    ack();
    mem_valid = 1; mem_pc = 32'h80003000; f_sys = 1; status = 32'h00008003; int_time = 1;
    check_now();
    chk("exl_code", {27'd0, exc_code}, 32'h08);
    advance();
    ack();

    // Store address error, then eret.
    mem_valid = 1; mem_pc = 32'h80004000; mem_addr = 32'h00000003; f_ades = 1;
    check_now();
    chk("ades_code", {27'd0, exc_code}, 32'h05);
    chk("ades_bad", exc_bad, 32'h00000003);
    advance();
    ack();
    mem_valid = 1; mem_pc = 32'h80004010; f_eret = 1;
    check_now();
    chk("eret_code", {27'd0, exc_code}, 32'h11);
    advance();
    clr();
    check_now();
    chk("eret_stall", {31'd0, stall}, 32'h1);
    advance();

    // Reset while waiting.
    rst_n = 0; step();
    rst_n = 1;
    check_now();
    chk("rst_wait_stall", {31'd0, stall}, 32'h0);
    chk("rst_wait_code", {27'd0, exc_code}, 32'h10);
    advance();

    // Reset clears a pending delay-slot flag.
    mem_valid = 1; mem_pc = 32'h80005000; mem_is_branch = 1; step();
    clr(); rst_n = 0; step();
    rst_n = 1; mem_valid = 1; mem_pc = 32'h80005004; f_sys = 1;
    check_now();
    chk("rst_delay", {31'd0, in_delay}, 32'h0);
    chk("rst_delay_epc", exc_epc, 32'h80005004);
    advance();
    clr();

    // No acknowledge for longer than the timeout.
    for (int i = 0; i < 20; i++) step();
    check_now();
`ifdef EXC_TIMEOUT_EN
    chk("to_stall", {31'd0, stall}, 32'h0);
    chk("to_flag", {31'd0, timeout}, 32'h1);
`else
    chk("to_stall", {31'd0, stall}, 32'h1);
    chk("to_flag", {31'd0, timeout}, 32'h0);
`endif
    advance();
    ack();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      mem_valid     = ($urandom_range(0, 3) != 0);
      mem_pc        = $urandom;
      mem_addr      = $urandom;
      mem_is_branch = ($urandom_range(0, 2) == 0);
      f_if_adel = ($urandom_range(0, 11) == 0);
      f_ri      = ($urandom_range(0, 11) == 0);
      f_ov      = ($urandom_range(0, 11) == 0);
      f_sys     = ($urandom_range(0, 11) == 0);
      f_bp      = ($urandom_range(0, 11) == 0);
      f_eret    = ($urandom_range(0, 11) == 0);
      f_adel    = ($urandom_range(0, 11) == 0);
      f_ades    = ($urandom_range(0, 11) == 0);
      status    = $urandom;
      cause     = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      int_time  = ($urandom_range(0, 7) == 0);
      jump      = ($urandom_range(0, 2) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
